// File: rtl/mult_div_ctrl.sv
// Multicycle signed multiply/divide sequencer producing HI/LO for MULT and DIV.
// Radix-2 Booth multiplier and restoring divider, one step per clock.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       state_dbg
);

    // Handshake: a start is accepted only in IDLE; busy rises the next cycle and
    // stays high through the one-cycle done pulse; hi/lo are valid from done onward.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MULT   = 3'd1,
        S_DIV    = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4,
        S_DZERO  = 3'd5
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH:0]   mcand;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;

    logic             last_step;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign state_dbg = state;
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mult_start)                    state_nxt = S_MULT;
                else if (div_start && op_b != '0)  state_nxt = S_DIV;
                else if (div_start)                state_nxt = S_DZERO;
            end
            S_MULT, S_DIV: begin
                busy = 1'b1;
                if (last_step) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DZERO: begin
                busy      = 1'b1;
                done      = 1'b1;
                div_zero  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Booth add/sub selected by {Q0, Q-1}; the extra accumulator bit keeps the
    // carry when the multiplicand is the most-negative value.
    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
    end

    // Partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)),
    // so the shifted value fits and diff[WIDTH] is a valid borrow flag.
    assign shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff    = shifted - mcand;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            mcand  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_MULT) begin
                        cnt    <= '0;
                        acc    <= '0;
                        q      <= op_b;
                        q_m1   <= 1'b0;
                        mcand  <= {op_a[WIDTH-1], op_a};
                        op_div <= 1'b0;
                    end else if (state_nxt == S_DIV) begin
                        cnt    <= '0;
                        acc    <= '0;
                        q      <= mag(op_a);
                        q_m1   <= 1'b0;
                        mcand  <= {1'b0, mag(op_b)};
                        op_div <= 1'b1;
                        neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_r  <= op_a[WIDTH-1];
                    end
                end
                S_MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt + CW'(1);
                end
                S_DIV: begin
                    if (diff[WIDTH]) begin
                        acc <= shifted;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= diff;
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + CW'(1);
                end
                S_FINISH: begin
                    if (op_div) begin
                        lo <= neg_q ? -q : q;
                        hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized and directed bench for mult_div_ctrl against a plain-arithmetic
// reference model (64-bit signed multiply, truncating divide/remainder).
module tb_mult_div_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [2:0]   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   mdl_hi = '0;
    logic [W-1:0]   mdl_lo = '0;

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo),
        .state_dbg  (state_dbg)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: pushes the expected {hi, lo} for each issued op
    function automatic void model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint r;
        longint rem;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            r = sa * sb;
            mdl_hi = r[63:32];
            mdl_lo = r[31:0];
        end else if (b != '0) begin
            r   = sa / sb;
            rem = sa % sb;
            mdl_lo = r[31:0];
            mdl_hi = rem[31:0];
        end
        exp_q.push_back({mdl_hi, mdl_lo});
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] specials[5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return W'($signed($urandom_range(0, 200)) - 100);
        return W'($urandom);
    endfunction

    // driver: called at a negedge; issues one op and checks its completion
    task automatic do_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_at);
        bit           dz;
        int           lat;
        int           exp_lat;
        logic [63:0]  e;
        dz      = !m && d && (b == '0);
        exp_lat = dz ? 1 : W + 2;
        model(m, a, b);
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = W'($urandom);
        op_b       = W'($urandom);
        lat        = 1;
        check("busy_start", 64'(busy), 64'(1));
        while (!done && lat < 200) begin
            mult_start = (lat == pulse_at);
            @(negedge clk);
            lat++;
        end
        mult_start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_at_done", 64'(busy), 64'(1));
        check("div_zero", 64'(div_zero), 64'(dz));
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e[63:32]));
        check("lo", 64'(lo), 64'(e[31:0]));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("hold", {hi, lo}, e);
    endtask

    initial begin
        int extra;
        int kind;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_zero), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // directed cases
        do_op(1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        check("mul_7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        check("mul_min2", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_m1m1", {hi, lo}, 64'h0000_0000_0000_0001);
        do_op(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        check("div_-7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(0, 1, 32'h0000_0007, 32'hFFFF_FFFE, 0);
        check("div_7/-2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min/-1", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(0, 1, 32'h0246_9234, 32'h0000_2000, 0);
        check("div_set1234", {hi, lo}, 64'h0000_1234_0000_1234);
        do_op(0, 1, 32'h0000_0005, 32'h0000_0000, 0);
        check("dz_hold", {hi, lo}, 64'h0000_1234_0000_1234);

        // both starts high; extra start mid-operation must be ignored
        do_op(1, 1, 32'd6, 32'd4, 10);
        check("both_lo", 64'(lo), 64'd24);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("extra_done", 64'(extra), 64'(0));

        // reset in the middle of a divide
        div_start = 1'b1;
        op_a      = 32'hFFFF_FF9C;
        op_b      = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        do_op(1, 0, 32'd3, 32'd5, 0);
        check("post_reset_lo", 64'(lo), 64'd15);

        // randomized mix
        for (int i = 0; i < 25; i++) begin
            kind = int'($urandom_range(0, 9));
            a = pick();
            b = pick();
            if (kind < 5) begin
                do_op(1, ($urandom_range(0, 3) == 0), a, b, 0);
            end else if (kind < 9) begin
                if (b == '0) b = 32'd3;
                do_op(0, 1, a, b, 0);
            end else begin
                do_op(0, 1, a, 32'h0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
